// File: rtl/alu_pipe_acc.sv
// Pipelined A +/- B + C unit with accumulator feedback, optional saturation,
// per-result and sticky overflow flags, and a valid pipeline under a global CE.
module alu_pipe_acc #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int R_WIDTH  = 24,
    parameter int IN_REG   = 1,
    parameter int OUT_REG  = 1,
    parameter int SATURATE = 0
) (
    input  logic               CLK0,
    input  logic               RST0,
    input  logic               CE,
    input  logic               CLR,
    input  logic               IN_VALID,
    input  logic               SIGNEDA,
    input  logic               SIGNEDB,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [R_WIDTH-1:0] CIN,
    input  logic               OPADDNSUB,
    input  logic               OPCINSEL,
    input  logic               OPACC,
    output logic               OUT_VALID,
    output logic [R_WIDTH-1:0] R,
    output logic               OVF,
    output logic               OVF_STICKY
);

    localparam int EW = R_WIDTH + 2;

    // Operands as seen by the accumulator stage
    logic               st_valid, st_clr, st_sa, st_sb, st_sub, st_cinsel, st_opacc;
    logic [A_WIDTH-1:0] st_a;
    logic [B_WIDTH-1:0] st_b;
    logic [R_WIDTH-1:0] st_cin;

    // CLR and CIN travel with their operation so every per-op input stays aligned.
    generate
        if (IN_REG != 0) begin : g_in_reg
            logic               valid_reg, clr_reg, sa_reg, sb_reg, sub_reg, cinsel_reg, opacc_reg;
            logic [A_WIDTH-1:0] a_reg;
            logic [B_WIDTH-1:0] b_reg;
            logic [R_WIDTH-1:0] cin_reg;

            always_ff @(posedge CLK0 or posedge RST0) begin
                if (RST0) begin
                    valid_reg  <= 1'b0;
                    clr_reg    <= 1'b0;
                    sa_reg     <= 1'b0;
                    sb_reg     <= 1'b0;
                    sub_reg    <= 1'b0;
                    cinsel_reg <= 1'b0;
                    opacc_reg  <= 1'b0;
                    a_reg      <= '0;
                    b_reg      <= '0;
                    cin_reg    <= '0;
                end else if (CE) begin
                    valid_reg  <= IN_VALID;
                    clr_reg    <= CLR;
                    sa_reg     <= SIGNEDA;
                    sb_reg     <= SIGNEDB;
                    sub_reg    <= OPADDNSUB;
                    cinsel_reg <= OPCINSEL;
                    opacc_reg  <= OPACC;
                    a_reg      <= A;
                    b_reg      <= B;
                    cin_reg    <= CIN;
                end
            end

            assign st_valid  = valid_reg;
            assign st_clr    = clr_reg;
            assign st_sa     = sa_reg;
            assign st_sb     = sb_reg;
            assign st_sub    = sub_reg;
            assign st_cinsel = cinsel_reg;
            assign st_opacc  = opacc_reg;
            assign st_a      = a_reg;
            assign st_b      = b_reg;
            assign st_cin    = cin_reg;
        end else begin : g_in_bypass
            assign st_valid  = IN_VALID;
            assign st_clr    = CLR;
            assign st_sa     = SIGNEDA;
            assign st_sb     = SIGNEDB;
            assign st_sub    = OPADDNSUB;
            assign st_cinsel = OPCINSEL;
            assign st_opacc  = OPACC;
            assign st_a      = A;
            assign st_b      = B;
            assign st_cin    = CIN;
        end
    endgenerate

    logic [R_WIDTH-1:0] acc_reg;
    logic               ovf_reg, s1_valid_reg, s1_clr_reg;

    logic               res_signed;
    logic [EW-1:0]      a_ext, b_ext, cin_ext, acc_ext, c_ext, full;
    logic               ovf_calc;
    logic [R_WIDTH-1:0] sat_val, res_calc;

    assign res_signed = st_sa | st_sb;
    assign a_ext      = {{(EW-A_WIDTH){st_sa & st_a[A_WIDTH-1]}}, st_a};
    assign b_ext      = {{(EW-B_WIDTH){st_sb & st_b[B_WIDTH-1]}}, st_b};
    assign cin_ext    = {{2{res_signed & st_cin[R_WIDTH-1]}}, st_cin};
    assign acc_ext    = {{2{res_signed & acc_reg[R_WIDTH-1]}}, acc_reg};

    // A clear arriving with an accumulate op restarts the sum from zero.
    always_comb begin
        c_ext = '0;
        if (st_opacc) begin
            if (!st_clr) c_ext = acc_ext;
        end else if (st_cinsel) begin
            c_ext = cin_ext;
        end
    end

    assign full = st_sub ? (a_ext - b_ext + c_ext) : (a_ext + b_ext + c_ext);

    // Signed: top three bits must agree. Unsigned: top two bits must be clear.
    always_comb begin
        if (res_signed)
            ovf_calc = !((&full[EW-1:R_WIDTH-1]) || !(|full[EW-1:R_WIDTH-1]));
        else
            ovf_calc = |full[EW-1:R_WIDTH];
        if (full[EW-1])
            sat_val = res_signed ? {1'b1, {(R_WIDTH-1){1'b0}}} : '0;
        else
            sat_val = res_signed ? {1'b0, {(R_WIDTH-1){1'b1}}} : '1;
        res_calc = ((SATURATE != 0) && ovf_calc) ? sat_val : full[R_WIDTH-1:0];
    end

    always_ff @(posedge CLK0 or posedge RST0) begin
        if (RST0) begin
            acc_reg      <= '0;
            ovf_reg      <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_clr_reg   <= 1'b0;
        end else if (CE) begin
            s1_valid_reg <= st_valid;
            s1_clr_reg   <= st_clr;
            if (st_valid) begin
                acc_reg <= res_calc;
                ovf_reg <= ovf_calc;
            end else if (st_clr) begin
                acc_reg <= '0;
            end
        end
    end

    // The sticky flag updates at the stage that drives the outputs, so it
    // always reflects exactly the results already presented.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic               valid_reg, ovf_out_reg, sticky_reg;
            logic [R_WIDTH-1:0] r_reg;

            always_ff @(posedge CLK0 or posedge RST0) begin
                if (RST0) begin
                    valid_reg   <= 1'b0;
                    ovf_out_reg <= 1'b0;
                    sticky_reg  <= 1'b0;
                    r_reg       <= '0;
                end else if (CE) begin
                    valid_reg   <= s1_valid_reg;
                    ovf_out_reg <= ovf_reg;
                    r_reg       <= acc_reg;
                    sticky_reg  <= s1_clr_reg ? 1'b0 : (sticky_reg | (s1_valid_reg & ovf_reg));
                end
            end

            assign OUT_VALID  = valid_reg;
            assign R          = r_reg;
            assign OVF        = ovf_out_reg;
            assign OVF_STICKY = sticky_reg;
        end else begin : g_out_bypass
            logic sticky_reg;

            always_ff @(posedge CLK0 or posedge RST0) begin
                if (RST0)
                    sticky_reg <= 1'b0;
                else if (CE)
                    sticky_reg <= st_clr ? 1'b0 : (sticky_reg | (st_valid & ovf_calc));
            end

            assign OUT_VALID  = s1_valid_reg;
            assign R          = acc_reg;
            assign OVF        = ovf_reg;
            assign OVF_STICKY = sticky_reg;
        end
    endgenerate

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Scoreboard bench for alu_pipe_acc: wrap and saturating instances share one
// stimulus stream; an arithmetic reference model predicts both result streams.
`timescale 1ns/1ps
module tb_alu_pipe_acc;

    localparam int AW = 18;
    localparam int BW = 18;
    localparam int RW = 24;
    localparam int LAT = 3;

    logic          CLK0 = 1'b0;
    logic          RST0, CE, CLR, IN_VALID, SIGNEDA, SIGNEDB, OPADDNSUB, OPCINSEL, OPACC;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic [RW-1:0] CIN;

    logic          ov_w, ovf_w, st_w;
    logic [RW-1:0] r_w;
    logic          ov_s, ovf_s, st_s;
    logic [RW-1:0] r_s;

    always #5 CLK0 = ~CLK0;

    alu_pipe_acc #(.A_WIDTH(AW), .B_WIDTH(BW), .R_WIDTH(RW), .IN_REG(1), .OUT_REG(1), .SATURATE(0)) dut (
        .CLK0(CLK0), .RST0(RST0), .CE(CE), .CLR(CLR), .IN_VALID(IN_VALID),
        .SIGNEDA(SIGNEDA), .SIGNEDB(SIGNEDB), .A(A), .B(B), .CIN(CIN),
        .OPADDNSUB(OPADDNSUB), .OPCINSEL(OPCINSEL), .OPACC(OPACC),
        .OUT_VALID(ov_w), .R(r_w), .OVF(ovf_w), .OVF_STICKY(st_w)
    );

    alu_pipe_acc #(.A_WIDTH(AW), .B_WIDTH(BW), .R_WIDTH(RW), .IN_REG(1), .OUT_REG(1), .SATURATE(1)) dut_sat (
        .CLK0(CLK0), .RST0(RST0), .CE(CE), .CLR(CLR), .IN_VALID(IN_VALID),
        .SIGNEDA(SIGNEDA), .SIGNEDB(SIGNEDB), .A(A), .B(B), .CIN(CIN),
        .OPADDNSUB(OPADDNSUB), .OPCINSEL(OPCINSEL), .OPACC(OPACC),
        .OUT_VALID(ov_s), .R(r_s), .OVF(ovf_s), .OVF_STICKY(st_s)
    );

    typedef struct {
        bit          v, clr, sa, sb, sub, cinsel, acc;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [RW-1:0] cin;
    } op_t;

    typedef struct {
        int            id;
        int            issue;
        logic [RW-1:0] r0;
        bit            o0, s0;
        logic [RW-1:0] r1;
        bit            o1, s1;
    } exp_t;

    exp_t   sb_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     ce_cnt   = 0;
    int     txn_id   = 0;
    longint acc_m[2];
    bit     st_m[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic longint to_int(input longint raw, input int w, input bit sgn);
        if (sgn && raw[w-1]) return raw - (longint'(1) << w);
        return raw;
    endfunction

    // Reference: evaluate the arithmetic on plain integers, then range-check.
    task automatic model_step(input int m, input bit sat, input op_t op,
                              output logic [RW-1:0] r, output bit ovf, output bit st);
        bit     sgn;
        longint av, bv, cv, full, lo, hi, res;
        sgn = op.sa | op.sb;
        av  = to_int(longint'(op.a), AW, op.sa);
        bv  = to_int(longint'(op.b), BW, op.sb);
        cv  = 0;
        if (op.acc) cv = op.clr ? 0 : to_int(acc_m[m], RW, sgn);
        else if (op.cinsel) cv = to_int(longint'(op.cin), RW, sgn);
        full = op.sub ? (av - bv + cv) : (av + bv + cv);
        lo   = sgn ? -(longint'(1) << (RW-1)) : 0;
        hi   = sgn ? ((longint'(1) << (RW-1)) - 1) : ((longint'(1) << RW) - 1);
        ovf  = (full < lo) || (full > hi);
        res  = (sat && ovf) ? ((full < lo) ? lo : hi) : full;
        r    = res[RW-1:0];
        if (op.v) begin
            acc_m[m] = longint'(r);
            st_m[m]  = op.clr ? 1'b0 : (st_m[m] | ovf);
        end else if (op.clr) begin
            acc_m[m] = 0;
            st_m[m]  = 1'b0;
        end
        st = st_m[m];
    endtask

    function automatic op_t mk(input bit v, input bit clr, input bit sa, input bit sb, input bit sub,
                               input bit cinsel, input bit acc, input logic [AW-1:0] a,
                               input logic [BW-1:0] b, input logic [RW-1:0] cin);
        op_t o;
        o.v = v; o.clr = clr; o.sa = sa; o.sb = sb; o.sub = sub;
        o.cinsel = cinsel; o.acc = acc; o.a = a; o.b = b; o.cin = cin;
        return o;
    endfunction

    function automatic op_t idle_op();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endfunction

    // One clock of stimulus; the model only advances when the DUT will capture it.
    task automatic drive(input op_t op, input bit ce);
        exp_t e;
        @(posedge CLK0);
        #1;
        CE = ce; IN_VALID = op.v; CLR = op.clr; SIGNEDA = op.sa; SIGNEDB = op.sb;
        OPADDNSUB = op.sub; OPCINSEL = op.cinsel; OPACC = op.acc;
        A = op.a; B = op.b; CIN = op.cin;
        if (ce) begin
            model_step(0, 1'b0, op, e.r0, e.o0, e.s0);
            model_step(1, 1'b1, op, e.r1, e.o1, e.s1);
            if (op.v) begin
                e.id    = txn_id;
                e.issue = ce_cnt;
                txn_id++;
                sb_q.push_back(e);
            end
        end
    endtask

    // Monitor: a new result is presented only after an enabled clock edge.
    logic [RW-1:0] prev_r;
    logic          prev_ov, prev_ovf, prev_st;
    bit            prev_ok = 1'b0;

    initial begin
        bit ce_q, rst_q;
        exp_t e;
        forever begin
            @(posedge CLK0);
            ce_q  = CE;
            rst_q = RST0;
            if (CE && !RST0) ce_cnt++;
            @(negedge CLK0);
            if (!RST0 && !rst_q) begin
                if (ce_q && (ov_w || ov_s)) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", {62'd0, ov_w, ov_s}, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn %0d wrap R=%h OVF=%b ST=%b | sat R=%h OVF=%b ST=%b | lat=%0d",
                                 e.id, r_w, ovf_w, st_w, r_s, ovf_s, st_s, ce_cnt - e.issue);
                        chk("valid_wrap", ov_w, 1);
                        chk("valid_sat", ov_s, 1);
                        chk("latency", ce_cnt - e.issue, LAT);
                        chk("r_wrap", r_w, e.r0);
                        chk("ovf_wrap", ovf_w, e.o0);
                        chk("sticky_wrap", st_w, e.s0);
                        chk("r_sat", r_s, e.r1);
                        chk("ovf_sat", ovf_s, e.o1);
                        chk("sticky_sat", st_s, e.s1);
                    end
                end else if (!ce_q && prev_ok) begin
                    chk("hold_r", r_w, prev_r);
                    chk("hold_valid", ov_w, prev_ov);
                    chk("hold_ovf", ovf_w, prev_ovf);
                    chk("hold_sticky", st_w, prev_st);
                end
            end
            prev_r = r_w; prev_ov = ov_w; prev_ovf = ovf_w; prev_st = st_w;
            prev_ok = !RST0;
        end
    end

    initial begin
        op_t o;
        RST0 = 1'b1; CE = 1'b0; CLR = 1'b0; IN_VALID = 1'b0; SIGNEDA = 1'b0; SIGNEDB = 1'b0;
        OPADDNSUB = 1'b0; OPCINSEL = 1'b0; OPACC = 1'b0; A = '0; B = '0; CIN = '0;
        acc_m[0] = 0; acc_m[1] = 0; st_m[0] = 1'b0; st_m[1] = 1'b0;
        #12;
        chk("reset_r", r_w, 0);
        chk("reset_valid", ov_w, 0);
        chk("reset_ovf", ovf_w, 0);
        chk("reset_sticky", st_w, 0);
        chk("reset_r_sat", r_s, 0);
        @(posedge CLK0); #3; RST0 = 1'b0;

        // Latency and plain unsigned add, then signed subtract
        drive(mk(1, 0, 0, 0, 0, 0, 0, 18'd5, 18'd3, '0), 1'b1);
        for (int i = 0; i < 4; i++) drive(idle_op(), 1'b1);
        drive(mk(1, 0, 1, 1, 1, 0, 0, 18'h3FFFE, 18'd7, '0), 1'b1);
        drive(mk(1, 0, 0, 0, 0, 1, 0, 18'd10, 18'd20, 24'hFFFFF0), 1'b1);
        drive(mk(1, 0, 1, 0, 0, 1, 0, 18'd1, 18'd2, 24'hFFFFFF), 1'b1);

        // Accumulate four times, then clear alongside the fifth
        drive(mk(0, 1, 0, 0, 0, 0, 0, '0, '0, '0), 1'b1);
        for (int i = 0; i < 4; i++) drive(mk(1, 0, 0, 0, 0, 0, 1, 18'd1000, '0, '0), 1'b1);
        drive(mk(1, 1, 0, 0, 0, 0, 1, 18'd1000, '0, '0), 1'b1);

        // Signed accumulation running past the positive bound
        drive(mk(0, 1, 0, 0, 0, 0, 0, '0, '0, '0), 1'b1);
        for (int i = 0; i < 65; i++) drive(mk(1, 0, 1, 1, 0, 0, 1, 18'd131071, '0, '0), 1'b1);
        drive(mk(1, 0, 0, 0, 1, 0, 0, 18'd0, 18'd1, '0), 1'b1);
        drive(mk(0, 1, 0, 0, 0, 0, 0, '0, '0, '0), 1'b1);

        // CE freeze plus bubbles through an accumulate stream
        for (int i = 0; i < 12; i++) begin
            o = mk((i % 3) != 1, 0, 0, 0, 0, 0, 1, AW'(100 + i), '0, '0);
            drive(o, !(i == 5 || i == 6));
        end
        for (int i = 0; i < 4; i++) drive(idle_op(), 1'b1);

        // Async reset with three operations in flight
        for (int i = 0; i < 3; i++) drive(mk(1, 0, 0, 0, 0, 0, 1, 18'd7, 18'd1, '0), 1'b1);
        #2; RST0 = 1'b1; IN_VALID = 1'b0;
        #1;
        chk("arst_r", r_w, 0);
        chk("arst_valid", ov_w, 0);
        chk("arst_ovf", ovf_w, 0);
        chk("arst_sticky", st_w, 0);
        chk("arst_valid_sat", ov_s, 0);
        sb_q.delete();
        acc_m[0] = 0; acc_m[1] = 0; st_m[0] = 1'b0; st_m[1] = 1'b0;
        repeat (2) @(posedge CLK0);
        #3; RST0 = 1'b0;
        for (int i = 0; i < 6; i++) drive(idle_op(), 1'b1);

        // Randomised mix of all operations, bubbles, clears and CE gaps
        for (int i = 0; i < 400; i++) begin
            o.v      = ($urandom_range(0, 3) != 0);
            o.clr    = ($urandom_range(0, 24) == 0);
            o.sa     = 1'($urandom);
            o.sb     = 1'($urandom);
            o.sub    = 1'($urandom);
            o.cinsel = ($urandom_range(0, 2) == 0);
            o.acc    = ($urandom_range(0, 4) < 2);
            o.a      = AW'($urandom);
            o.b      = BW'($urandom);
            o.cin    = RW'($urandom);
            drive(o, $urandom_range(0, 9) != 0);
        end
        for (int i = 0; i < 8; i++) drive(idle_op(), 1'b1);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
